spmv_y_writer: RTL

Consumer of the intermediator's finished-row stream (`push_to_y` / `v_to_y`) in the MAC datapath. It converts each 66-bit FloPoCo-format result to an IEEE-754 double. It buffers results in a FIFO and issues sequential 64-bit memory writes to the y vector, honouring memory-controller stall. It flushes on end-of-file and signals `done` once every accepted result has been written.

---
 rtl/spmv_pkg.sv | 31 +++
 rtl/spmv_y_writer_if.sv | 26 ++
 rtl/std_fifo.sv | 50 +++++
 rtl/spmv_y_writer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/spmv_pkg.sv
// Shared SpMV datapath definitions: FloPoCo exception codes, the writer state
// encoding and the FloPoCo-to-IEEE-754 double conversion.
package spmv_pkg;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  localparam logic [63:0] IEEE_NAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Special cases collapse to canonical encodings; only the sign survives for zero and infinity.
  function automatic logic [63:0] flopoco_to_ieee(input logic [65:0] v);
    logic [63:0] r;
    case (v[65:64])
      EXC_ZERO:   r = {v[63], 63'b0};
      EXC_NORMAL: r = v[63:0];
      EXC_INF:    r = {v[63], 11'h7FF, 52'b0};
      default:    r = IEEE_NAN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spmv_y_writer_if.sv
// Memory write port of the y-vector writer: request/address/data out,
// stall back from the memory controller.
interface spmv_y_writer_if #(
  parameter int ADDR_W = 48
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_data;
  logic              mem_stall;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_stall
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_stall
  );

endinterface

// File: rtl/std_fifo.sv
// Synchronous FIFO with registered occupancy and a combinational read port,
// so a pop can load a downstream register in the same cycle.
module std_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             doWrite;
  logic             doRead;

  assign full_o    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doWrite   = wr_en_i && !full_o;
  assign doRead    = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (doWrite) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (doRead)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (doWrite && !doRead)      count_q <= count_q + 1'b1;
      else if (doRead && !doWrite) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (doWrite) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/spmv_y_writer.sv
// Drains the intermediator's finished rows into the y vector: convert, buffer,
// and write sequential doubles to memory, signalling done after end-of-file.
module spmv_y_writer #(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] y_base,
  input  logic              push,
  input  logic [65:0]       v,
  input  logic              eof,
  spmv_y_writer_if.master   mem,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       rows_written
);

  import spmv_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] y_base_q, y_base_d;
  logic              cap_valid_q, cap_valid_d;
  logic [63:0]       cap_data_q, cap_data_d;
  logic              cap_eof_q, cap_eof_d;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_data_q, out_data_d;
  logic [31:0]       rows_q, rows_d;
  logic              overflow_q, overflow_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [63:0]       fifo_rd_data;
  logic              startNow;
  logic              acceptPush;
  logic              memAccept;
  logic              flushDone;
  logic [34:0]       byteOffset;

  // eof travels with the capture stage so FLUSH only looks at data already in flight.
  assign startNow   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign acceptPush = push && (startNow || (state_q == ST_RUN && !cap_eof_q));
  assign memAccept  = out_valid_q && !mem.mem_stall;
  assign fifo_pop   = !fifo_empty && (!out_valid_q || memAccept);
  assign flushDone  = !cap_valid_q && fifo_empty && (!out_valid_q || memAccept);

  std_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cap_valid_q),
    .wr_data_i(cap_data_q),
    .rd_en_i  (fifo_pop),
    .rd_data_o(fifo_rd_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (cap_eof_q) state_d = ST_FLUSH;
      ST_FLUSH: if (flushDone) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    y_base_d    = y_base_q;
    rows_d      = rows_q;
    overflow_d  = overflow_q;
    cap_valid_d = acceptPush;
    cap_data_d  = acceptPush ? flopoco_to_ieee(v) : cap_data_q;
    cap_eof_d   = eof && (state_q == ST_RUN);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (fifo_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_rd_data;
    end else if (memAccept) begin
      out_valid_d = 1'b0;
    end

    if (memAccept) rows_d = rows_q + 32'd1;
    // A full FIFO drops the value; there is no upstream backpressure to apply.
    if (cap_valid_q && fifo_full) overflow_d = 1'b1;

    if (startNow) begin
      y_base_d   = y_base;
      rows_d     = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      y_base_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_eof_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rows_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_base_q    <= y_base_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_eof_q   <= cap_eof_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rows_q      <= rows_d;
      overflow_q  <= overflow_d;
    end
  end

  assign byteOffset   = {rows_q, 3'b000};
  assign mem.mem_req  = out_valid_q;
  assign mem.mem_data = out_data_q;
  assign mem.mem_addr = y_base_q + ADDR_W'(byteOffset);
  assign done         = (state_q == ST_DONE);
  assign overflow     = overflow_q;
  assign rows_written = rows_q;

endmodule
